// File: rtl/md_hazard_if.sv
// Hazard-controller bundle: operand/producer info in from the datapath, pipeline
// enables/clears and MD/stall status back out.
interface md_hazard_if;
  // Every signal is a level, valid every cycle. There is no valid/ready
  // handshake: the datapath presents hazard info each cycle and consumes the
  // controls at the next rising edge.
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_rs_tuse;
  logic [1:0]  D_rt_tuse;
  logic [4:0]  E_wa;
  logic [1:0]  E_tnew;
  logic [4:0]  M_wa;
  logic [1:0]  M_tnew;
  logic        D_is_md;
  logic        E_md_start;
  logic        E_md_div;
  logic        flush_req;
  logic        PC_en;
  logic        FD_en;
  logic        FD_clear;
  logic        DE_clear;
  logic        EM_en;
  logic        EM_clear;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_rs_tuse, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew,
           D_is_md, E_md_start, E_md_div, flush_req,
    input  PC_en, FD_en, FD_clear, DE_clear, EM_en, EM_clear, md_busy, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew,
           D_is_md, E_md_start, E_md_div, flush_req,
    output PC_en, FD_en, FD_clear, DE_clear, EM_en, EM_clear, md_busy, stall_cnt
  );
endinterface

// File: rtl/md_hazard_ctrl.sv
// Stall/flush controller for the five-stage core: Tuse/Tnew register hazards,
// multiply/divide occupancy counter and a stall-cycle performance counter.
module md_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_hazard_if.slave  hz
);

  localparam logic [3:0] LP_MULT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV  = 4'(DIV_CYCLES);

  logic [3:0]  r_md_cnt;
  logic [31:0] r_stall_cnt;

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;
  logic w_md_busy;
  logic w_md_load;

  // A producer blocks D when it writes the operand and its result is not
  // forwardable by the time D needs it. $0 never creates a dependency.
  always_comb begin
    w_stall_rs = (hz.D_rs != 5'd0) &&
                 (((hz.E_wa == hz.D_rs) && (hz.E_tnew > hz.D_rs_tuse)) ||
                  ((hz.M_wa == hz.D_rs) && (hz.M_tnew > hz.D_rs_tuse)));
    w_stall_rt = (hz.D_rt != 5'd0) &&
                 (((hz.E_wa == hz.D_rt) && (hz.E_tnew > hz.D_rt_tuse)) ||
                  ((hz.M_wa == hz.D_rt) && (hz.M_tnew > hz.D_rt_tuse)));
  end

  assign w_md_busy  = (r_md_cnt != 4'd0);
  assign w_stall_md = hz.D_is_md && (w_md_busy || hz.E_md_start);
  assign w_stall    = (w_stall_rs || w_stall_rt || w_stall_md) && !hz.flush_req;
  assign w_md_load  = hz.E_md_start && !hz.flush_req;

  assign hz.PC_en     = !w_stall;
  assign hz.FD_en     = !w_stall;
  assign hz.FD_clear  = hz.flush_req;
  assign hz.DE_clear  = w_stall || hz.flush_req;
  assign hz.EM_en     = 1'b1;
  assign hz.EM_clear  = hz.flush_req;
  assign hz.md_busy   = w_md_busy;
  assign hz.stall_cnt = r_stall_cnt;

  // A new start reloads even over an in-flight op; a flush only suppresses
  // the start, it never cancels an op already counting down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt    <= 4'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_md_load) begin
        r_md_cnt <= hz.E_md_div ? LP_DIV : LP_MULT;
      end else if (w_md_busy) begin
        r_md_cnt <= r_md_cnt - 4'd1;
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Bench for md_hazard_ctrl: directed scenarios then random cycles, checked by a
// queue-based scoreboard against a cycle-indexed reference model.
module tb_md_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int EXP_W  = 39;

  typedef struct packed {
    logic       reset;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       d_is_md;
    logic       start;
    logic       div;
    logic       flush;
  } stim_t;

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  md_hazard_if u_if ();

  md_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (u_if.slave)
  );

  // scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // reference model: md unit busy through cycle busy_until (inclusive)
  int          cyc = 0;
  int          busy_until = -1;
  logic [31:0] m_stall_cnt = '0;
  stim_t       prev;
  bit          prev_stall = 1'b0;

  function automatic bit operand_blocked(input logic [4:0] r, input logic [1:0] tuse,
                                         input stim_t s);
    logic [4:0] wa[2];
    logic [1:0] tn[2];
    bit blocked = 1'b0;
    wa[0] = s.e_wa; tn[0] = s.e_tnew;
    wa[1] = s.m_wa; tn[1] = s.m_tnew;
    if (r == 5'd0) return 1'b0;
    for (int p = 0; p < 2; p++)
      if (wa[p] == r && int'(tn[p]) > int'(tuse)) blocked = 1'b1;
    return blocked;
  endfunction

  // driver: one call = one clock cycle of stimulus
  task automatic apply(input stim_t s);
    bit busy;
    bit stall;
    @(posedge clk);
    #1;
    cyc++;
    if (prev.reset) begin
      busy_until  = -1;
      m_stall_cnt = '0;
    end else begin
      if (prev.start && !prev.flush)
        busy_until = (cyc - 1) + (prev.div ? DIV_N : MULT_N);
      if (prev_stall) m_stall_cnt = m_stall_cnt + 32'd1;
    end
    reset             = s.reset;
    u_if.D_rs         = s.d_rs;
    u_if.D_rt         = s.d_rt;
    u_if.D_rs_tuse    = s.rs_tuse;
    u_if.D_rt_tuse    = s.rt_tuse;
    u_if.E_wa         = s.e_wa;
    u_if.E_tnew       = s.e_tnew;
    u_if.M_wa         = s.m_wa;
    u_if.M_tnew       = s.m_tnew;
    u_if.D_is_md      = s.d_is_md;
    u_if.E_md_start   = s.start;
    u_if.E_md_div     = s.div;
    u_if.flush_req    = s.flush;
    busy  = (cyc <= busy_until);
    stall = !s.flush && (operand_blocked(s.d_rs, s.rs_tuse, s) ||
                         operand_blocked(s.d_rt, s.rt_tuse, s) ||
                         (s.d_is_md && (busy || s.start)));
    exp_q.push_back({!stall, !stall, s.flush, stall || s.flush, 1'b1, s.flush,
                     busy, m_stall_cnt});
    prev       = s;
    prev_stall = stall;
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.rs_tuse = 2'd3;
    s.rt_tuse = 2'd3;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.reset   = ($urandom_range(0, 49) == 0);
    s.d_rs    = 5'($urandom_range(0, 3));
    s.d_rt    = 5'($urandom_range(0, 3));
    s.rs_tuse = 2'($urandom_range(0, 3));
    s.rt_tuse = 2'($urandom_range(0, 3));
    s.e_wa    = 5'($urandom_range(0, 3));
    s.e_tnew  = 2'($urandom_range(0, 3));
    s.m_wa    = 5'($urandom_range(0, 3));
    s.m_tnew  = 2'($urandom_range(0, 3));
    s.d_is_md = ($urandom_range(0, 3) == 0);
    s.start   = ($urandom_range(0, 9) == 0);
    s.div     = 1'($urandom_range(0, 1));
    s.flush   = ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  // monitor: outputs are combinational, sampled mid-cycle on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] g;
      e = exp_q.pop_front();
      g = {u_if.PC_en, u_if.FD_en, u_if.FD_clear, u_if.DE_clear, u_if.EM_en,
           u_if.EM_clear, u_if.md_busy, u_if.stall_cnt};
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL outputs cyc=%0d got pc/fd/fdc/dec/em/emc/busy=%b cnt=%0d exp %b cnt=%0d",
                 cyc, g[38:32], g[31:0], e[38:32], e[31:0]);
      end
    end
  end

  initial begin
    stim_t s;
    prev = idle();
    prev.reset = 1'b1;
    reset = 1'b1;
    u_if.D_rs = '0; u_if.D_rt = '0; u_if.D_rs_tuse = 2'd3; u_if.D_rt_tuse = 2'd3;
    u_if.E_wa = '0; u_if.E_tnew = '0; u_if.M_wa = '0; u_if.M_tnew = '0;
    u_if.D_is_md = 1'b0; u_if.E_md_start = 1'b0; u_if.E_md_div = 1'b0;
    u_if.flush_req = 1'b0;

    // reset then idle
    s = idle(); s.reset = 1'b1; apply(s);
    for (int i = 0; i < 3; i++) apply(idle());

    // load-use on rs: stalls with tnew 2, not with tnew 1
    s = idle(); s.e_wa = 5'd1; s.e_tnew = 2'd2; s.d_rs = 5'd1; s.rs_tuse = 2'd1;
    apply(s); apply(s);
    s.e_tnew = 2'd1; apply(s);
    s = idle(); s.m_wa = 5'd7; s.m_tnew = 2'd1; s.d_rt = 5'd7; s.rt_tuse = 2'd0;
    apply(s);

    // mult with dependent MD instruction held in D
    s = idle(); s.start = 1'b1; s.div = 1'b0; s.d_is_md = 1'b1; apply(s);
    s.start = 1'b0;
    for (int i = 1; i <= 7; i++) apply(s);

    // div without MD in D, then MD enters D at cycle 7
    s = idle(); s.start = 1'b1; s.div = 1'b1; apply(s);
    s.start = 1'b0;
    for (int i = 1; i <= 6; i++) apply(s);
    s.d_is_md = 1'b1;
    for (int i = 7; i <= 12; i++) apply(s);

    // flush over rs hazard and busy unit, with a start that must be ignored
    s = idle(); s.start = 1'b1; s.div = 1'b1; apply(s);
    s = idle(); s.e_wa = 5'd3; s.e_tnew = 2'd2; s.d_rs = 5'd3; s.rs_tuse = 2'd0;
    s.d_is_md = 1'b1; s.flush = 1'b1; s.start = 1'b1; s.div = 1'b0;
    apply(s);
    s.start = 1'b0; s.flush = 1'b0; s.d_is_md = 1'b0;
    for (int i = 0; i < 10; i++) apply(s);

    // register 0 never hazards
    s = idle(); s.e_wa = 5'd0; s.e_tnew = 2'd2; s.m_wa = 5'd0; s.m_tnew = 2'd3;
    s.rs_tuse = 2'd0; s.rt_tuse = 2'd0;
    apply(s);

    // reset at cycle 3 of a div, after some stalls were counted
    s = idle(); s.start = 1'b1; s.div = 1'b1; s.d_is_md = 1'b1; apply(s);
    s.start = 1'b0; apply(s); apply(s);
    s.reset = 1'b1; apply(s);
    s = idle(); apply(s); apply(s);

    // random traffic
    for (int i = 0; i < 600; i++) apply(rand_stim());
    apply(idle());

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_hazard_ctrl.md
# md_hazard_ctrl

Pipeline stall/flush controller for the five-stage core. It computes the enable and clear controls for the F/D, D/E and E/M pipeline registers, and the PC enable, from three inputs: Tuse/Tnew register-hazard information, the occupancy of the multiply/divide unit and an external flush request. It owns the multiply/divide busy counter, which sets how long HI/LO-dependent instructions are held in D. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- D_rs  input  5  rs field of the instruction in D
- D_rt  input  5  rt field of the instruction in D
- D_rs_tuse  input  2  cycles until D needs rs (0..2; 3 = never used)
- D_rt_tuse  input  2  cycles until D needs rt (0..2; 3 = never used)
- E_wa  input  5  destination register of the instruction in E (0 = no write)
- E_tnew  input  2  cycles until E's result is forwardable
- M_wa  input  5  destination register of the instruction in M
- M_tnew  input  2  cycles until M's result is forwardable
- D_is_md  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_md_start  input  1  E instruction starts a mult/div this cycle
- E_md_div  input  1  qualifies E_md_start: 1 = divide, 0 = multiply
- flush_req  input  1  exception/eret flush request
- PC_en  output  1  PC write enable
- FD_en  output  1  F/D register enable
- FD_clear  output  1  F/D register clear
- DE_clear  output  1  D/E register clear (bubble insert)
- EM_en  output  1  E/M register enable
- EM_clear  output  1  E/M register clear
- md_busy  output  1  multiply/divide unit occupied
- stall_cnt  output  32  number of cycles in which stall was asserted

## Operation
- Register hazard on rs, evaluated combinationally: stall_rs = (D_rs != 0) && ((E_wa == D_rs && E_tnew > D_rs_tuse) || (M_wa == D_rs && M_tnew > D_rs_tuse)).
- stall_rt is defined the same way, using D_rt and D_rt_tuse.
- MD hazard: stall_md = D_is_md && (md_busy || E_md_start).
- Stall condition: stall = (stall_rs || stall_rt || stall_md) && !flush_req. A flush overrides a stall.
- Outputs:
  - PC_en = FD_en = !stall.
  - DE_clear = stall || flush_req.
  - FD_clear = flush_req.
  - EM_clear = flush_req.
  - EM_en = 1 always.
- Busy counter md_cnt is 4 bits wide, sized to hold DIV_CYCLES. md_busy = (md_cnt != 0).
- Busy counter update, evaluated at each clock edge in priority order:
  - reset: md_cnt <= 0.
  - E_md_start && !flush_req: md_cnt <= E_md_div ? DIV_CYCLES : MULT_CYCLES. This reloads even if the counter is still nonzero.
  - md_cnt != 0: md_cnt <= md_cnt - 1.
- flush_req does not cancel an operation already in flight; md_cnt keeps counting down.
- A start that coincides with flush_req is ignored.
- stall_cnt increments by 1 at every edge where stall = 1. It wraps from 0xFFFFFFFF to 0 and is cleared by reset.

## Timing
- All enable/clear outputs are combinational from the current inputs and md_cnt. They take effect at the same edge as the pipeline registers they control.
- Reset values:
  - md_cnt = 0, so md_busy = 0.
  - stall_cnt = 0.
  - With idle inputs after reset: PC_en = FD_en = EM_en = 1; FD_clear = DE_clear = EM_clear = 0.
- mult started in cycle t: md_busy is high in cycles t+1 .. t+5 and low from t+6. A dependent mflo in D stalls in cycles t .. t+5.
- div started in cycle t: md_busy is high in cycles t+1 .. t+10.
- Tnew values are supplied per stage by the datapath. This block does no aging of Tnew.
- Register 0 never causes a hazard, whatever the write addresses are.
- Reset asserted mid-operation clears md_cnt and stall_cnt at that edge.

## Test plan
- lw $1 in E (E_wa=1, E_tnew=2), addu using $1 in D (D_rs=1, D_rs_tuse=1) -> stall=1: PC_en=0, FD_en=0, DE_clear=1, stall_cnt +1. With E_tnew=1 under the same conditions -> no stall.
- E_md_start=1, E_md_div=0 at cycle 0, with D_is_md=1 held -> FD_en=0 in cycles 0..5 and 1 in cycle 6. md_busy is high in cycles 1..5.
- div start at cycle 0, D_is_md=0 -> md_busy high in cycles 1..10 with no stall. An MD instruction entering D at cycle 7 stalls through cycle 10.
- flush_req=1 while an rs hazard and md_busy are present -> PC_en=1, FD_clear=DE_clear=EM_clear=1, stall_cnt unchanged, md_cnt keeps decrementing. E_md_start in the same cycle does not load md_cnt.
- D_rs=0 with E_wa=0 and E_tnew=2 -> no stall.
- Reset pulsed at cycle 3 of a div -> md_busy=0 and stall_cnt=0 on the next cycle.
